// File: rtl/dino_pkg.sv
// Shared types and helpers for the obstacle scheduler and its LFSR core.
package dino_pkg;

   localparam int LFSR_W = 5;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'b00001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      COUNT = 2'd2,
      SPAWN = 2'd3
   } sched_state_t;

   // Maximal-length 5-bit Fibonacci step (period 31 from any nonzero state).
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
      return {r[3:0], r[1] ^ r[4]};
   endfunction

endpackage

// File: rtl/lfsr5_core.sv
// 5-bit LFSR register with a step enable; an all-zero state reloads SEED.
module lfsr5_core
   import dino_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step_i,
   output logic [LFSR_W-1:0] value_o
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   // Zero recovery takes priority over stepping: zero is a lock-up state.
   always_comb begin
      lfsr_d = lfsr_q;
      if (lfsr_q == '0) begin
         lfsr_d = SEED;
      end else if (step_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value_o = lfsr_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler sharing one LFSR with an external requester
// through a two-way round-robin arbiter.
module obstacle_scheduler
   import dino_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
   parameter int                GAP_MIN   = 40,
   parameter int                GAP_SHIFT = 1,
   parameter int                GW        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              game_run,
   input  logic              game_over,
   input  logic              tick,
   input  logic              button,
   input  logic              ext_req,
   output logic              ext_gnt,
   output logic [LFSR_W-1:0] ext_rnd,
   output logic              spawn,
   output logic              spawn_type,
   output logic              busy,
   output sched_state_t      dbg_state,
   output logic [LFSR_W-1:0] dbg_lfsr
);

   // Handshake: ext_req is a one-cycle pulse latched into ext_pend_q; requests
   // arriving while one is pending are merged. The grant is reported as a
   // one-cycle ext_gnt pulse the cycle after the win, with ext_rnd valid then
   // and held until the next grant.

   sched_state_t      state_q, state_d;
   logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
   logic              spawn_type_q, spawn_type_d;
   logic              ext_pend_q, ext_pend_d;
   logic              ext_gnt_q, ext_gnt_d;
   logic [LFSR_W-1:0] ext_rnd_q, ext_rnd_d;
   logic              rr_ptr_q, rr_ptr_d;

   logic [LFSR_W-1:0] lfsr;
   logic              run_ok;
   logic              int_req;
   logic              int_win;
   logic              ext_win;
   logic              lfsr_step;
   logic [GW-1:0]     gap_load;

   lfsr5_core #(
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .step_i  (lfsr_step),
      .value_o (lfsr)
   );

   // An aborting LOAD does not request, so no draw is wasted on a dead round.
   assign run_ok  = game_run & ~game_over;
   assign int_req = (state_q == LOAD) & run_ok;

   // rr_ptr_q = 0 favours the scheduler, 1 favours the external consumer.
   assign int_win = int_req & (~ext_pend_q | ~rr_ptr_q);
   assign ext_win = ext_pend_q & (~int_req | rr_ptr_q);

   assign lfsr_step = button | int_win | ext_win;
   assign gap_load  = GW'(GAP_MIN) + (GW'(lfsr) << GAP_SHIFT);

   always_comb begin
      state_d      = state_q;
      gap_cnt_d    = gap_cnt_q;
      spawn_type_d = spawn_type_q;
      spawn        = 1'b0;
      if (!run_ok) begin
         state_d   = IDLE;
         gap_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = LOAD;
            end
            LOAD: begin
               if (int_win) begin
                  gap_cnt_d    = gap_load;
                  spawn_type_d = lfsr[0];
                  state_d      = COUNT;
               end
            end
            COUNT: begin
               if (tick) begin
                  gap_cnt_d = gap_cnt_q - GW'(1);
                  if (gap_cnt_q == GW'(1)) begin
                     state_d = SPAWN;
                  end
               end
            end
            SPAWN: begin
               spawn   = 1'b1;
               state_d = LOAD;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      ext_gnt_d  = ext_win;
      ext_pend_d = ext_win ? 1'b0 : (ext_pend_q | ext_req);
      ext_rnd_d  = ext_win ? lfsr : ext_rnd_q;
      rr_ptr_d   = rr_ptr_q;
      if (int_win) begin
         rr_ptr_d = 1'b1;
      end else if (ext_win) begin
         rr_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         gap_cnt_q    <= '0;
         spawn_type_q <= 1'b0;
         ext_pend_q   <= 1'b0;
         ext_gnt_q    <= 1'b0;
         ext_rnd_q    <= '0;
         rr_ptr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_cnt_q    <= gap_cnt_d;
         spawn_type_q <= spawn_type_d;
         ext_pend_q   <= ext_pend_d;
         ext_gnt_q    <= ext_gnt_d;
         ext_rnd_q    <= ext_rnd_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign ext_gnt    = ext_gnt_q;
   assign ext_rnd    = ext_rnd_q;
   assign spawn_type = spawn_type_q;
   assign busy       = (state_q != IDLE);
   assign dbg_state  = state_q;
   assign dbg_lfsr   = lfsr;

endmodule
